// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with a zero-latency lookup and a one-edge update path.
// Optional macro BP_SATCNT_EN adds a 2-bit saturating direction counter per entry.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module branch_predictor #(
  parameter int BTB_IDX_BITS = 4,
  parameter int WORD_SIZE    = `WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] PC_IF,
  output logic [WORD_SIZE-1:0] predPC,
  output logic                 pred_taken,
  input  logic                 update_en,
  input  logic [WORD_SIZE-1:0] update_PC,
  input  logic [WORD_SIZE-1:0] update_target,
  input  logic                 update_taken,
  input  logic                 btb_flush
);

  localparam int ENTRIES = 1 << BTB_IDX_BITS;
  localparam int TAG_W   = WORD_SIZE - BTB_IDX_BITS;
  localparam logic [WORD_SIZE-1:0] PC_STEP = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  logic [ENTRIES-1:0]   valid_q;
  logic [ENTRIES-1:0]   valid_d;
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [WORD_SIZE-1:0] target_q [ENTRIES];

  logic [BTB_IDX_BITS-1:0] rd_idx_s;
  logic [BTB_IDX_BITS-1:0] wr_idx_s;
  logic                    rd_hit_s;
  logic                    wr_hit_s;
  logic                    wr_ok_s;
  logic                    entry_we_s;

  assign rd_idx_s = PC_IF[BTB_IDX_BITS-1:0];
  assign wr_idx_s = update_PC[BTB_IDX_BITS-1:0];
  assign rd_hit_s = valid_q[rd_idx_s] && (tag_q[rd_idx_s] == PC_IF[WORD_SIZE-1:BTB_IDX_BITS]);
  assign wr_hit_s = valid_q[wr_idx_s] && (tag_q[wr_idx_s] == update_PC[WORD_SIZE-1:BTB_IDX_BITS]);
  // Flush and reset both suppress any update landing on the same edge.
  assign wr_ok_s  = update_en && !btb_flush && !reset;

  // Taken updates always write tag and target: allocation on a miss, refresh on a hit.
  assign entry_we_s = wr_ok_s && update_taken;

`ifdef BP_SATCNT_EN
  logic [1:0] cnt_q [ENTRIES];
  logic [1:0] cnt_d;

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    logic [1:0] res;
    if (up) begin
      res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
    return res;
  endfunction

  // Next counter value for the entry addressed by the update port.
  always_comb begin
    cnt_d = cnt_q[wr_idx_s];
    if (wr_ok_s && wr_hit_s) begin
      cnt_d = sat_step(cnt_q[wr_idx_s], update_taken);
    end else if (wr_ok_s && update_taken) begin
      cnt_d = 2'b10;
    end else begin
      cnt_d = cnt_q[wr_idx_s];
    end
  end

  // Valid vector next state: counters never clear valid, only a flush does.
  always_comb begin
    valid_d = valid_q;
    if (btb_flush) begin
      valid_d = '0;
    end else if (entry_we_s) begin
      valid_d[wr_idx_s] = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // Counter storage; reset parks every counter at weakly-not-taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= 2'b01;
      end
    end else if (wr_ok_s) begin
      cnt_q[wr_idx_s] <= cnt_d;
    end else begin
      cnt_q[wr_idx_s] <= cnt_q[wr_idx_s];
    end
  end

  assign pred_taken = rd_hit_s && cnt_q[rd_idx_s][1];
`else
  // Valid vector next state: a not-taken outcome on a hit evicts the entry.
  always_comb begin
    valid_d = valid_q;
    if (btb_flush) begin
      valid_d = '0;
    end else if (entry_we_s) begin
      valid_d[wr_idx_s] = 1'b1;
    end else if (wr_ok_s && wr_hit_s) begin
      valid_d[wr_idx_s] = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  assign pred_taken = rd_hit_s;
`endif

  assign predPC = pred_taken ? target_q[rd_idx_s] : PC_IF + PC_STEP;

  // Valid bits: reset and flush clear everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and target payload; only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (entry_we_s) begin
      tag_q[wr_idx_s]    <= update_PC[WORD_SIZE-1:BTB_IDX_BITS];
      target_q[wr_idx_s] <= update_target;
    end else begin
      tag_q[wr_idx_s]    <= tag_q[wr_idx_s];
      target_q[wr_idx_s] <= target_q[wr_idx_s];
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Table-driven directed bench for branch_predictor; expectations follow the build's BP_SATCNT_EN setting.
module tb_branch_predictor;

`ifdef BP_SATCNT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] PC_IF;
  logic [15:0] predPC;
  logic        pred_taken;
  logic        update_en;
  logic [15:0] update_PC;
  logic [15:0] update_target;
  logic        update_taken;
  logic        btb_flush;

  int checks;
  int failures;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        ue;
    logic        ut;
    logic [15:0] upc;
    logic [15:0] utgt;
    logic [15:0] pc;
    logic [15:0] exp_pc;
    logic        exp_tk;
  } vec_t;

  vec_t vecs [40];
  int   nv;

  branch_predictor #(.BTB_IDX_BITS(4), .WORD_SIZE(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .PC_IF        (PC_IF),
    .predPC       (predPC),
    .pred_taken   (pred_taken),
    .update_en    (update_en),
    .update_PC    (update_PC),
    .update_target(update_target),
    .update_taken (update_taken),
    .btb_flush    (btb_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic flush, input logic ue, input logic ut,
                              input logic [15:0] upc, input logic [15:0] utgt, input logic [15:0] pc,
                              input logic [15:0] exp_pc, input logic exp_tk);
    vec_t v;
    v.rst = rst; v.flush = flush; v.ue = ue; v.ut = ut;
    v.upc = upc; v.utgt = utgt; v.pc = pc; v.exp_pc = exp_pc; v.exp_tk = exp_tk;
    return v;
  endfunction

  task automatic add(input vec_t v);
    vecs[nv] = v;
    nv = nv + 1;
  endtask

  task automatic check(input string nm, input int idx, input logic [15:0] act_pc, input logic act_tk,
                       input logic [15:0] exp_pc, input logic exp_tk);
    checks = checks + 1;
    if (act_pc !== exp_pc) begin
      failures = failures + 1;
      $display("FAIL %s[%0d] predPC got=%h expected=%h", nm, idx, act_pc, exp_pc);
    end
    checks = checks + 1;
    if (act_tk !== exp_tk) begin
      failures = failures + 1;
      $display("FAIL %s[%0d] pred_taken got=%b expected=%b", nm, idx, act_tk, exp_tk);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    nv = 0;

    // Stimulus table: outputs are checked before the vector's own edge commits.
    add(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0010, 16'h0011, 1'b0));
    add(mk(1'b0, 1'b0, 1'b1, 1'b1, 16'h0012, 16'h0040, 16'h0012, 16'h0013, 1'b0));
    add(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0012, 16'h0040, 1'b1));
    add(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0012, 16'h0000, 16'h0012, 16'h0040, 1'b1));
    add(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0012, 16'h0000, 16'h0012, 16'h0013, 1'b0));
    add(mk(1'b0, 1'b0, 1'b1, 1'b1, 16'h0012, 16'h0040, 16'h0012, 16'h0013, 1'b0));
    add(mk(1'b0, 1'b0, 1'b1, 1'b1, 16'h0012, 16'h0040, 16'h0012, SAT ? 16'h0013 : 16'h0040, !SAT));
    add(mk(1'b0, 1'b0, 1'b1, 1'b1, 16'h0012, 16'h0040, 16'h0012, 16'h0040, 1'b1));
    add(mk(1'b0, 1'b0, 1'b1, 1'b1, 16'h0012, 16'h0040, 16'h0012, 16'h0040, 1'b1));
    add(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0012, 16'h0000, 16'h0012, 16'h0040, 1'b1));
    add(mk(1'b0, 1'b0, 1'b1, 1'b1, 16'h0012, 16'h0050, 16'h0012, SAT ? 16'h0040 : 16'h0013, SAT));
    add(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0012, 16'h0099, 16'h0012, 16'h0050, 1'b1));
    add(mk(1'b0, 1'b0, 1'b1, 1'b1, 16'h0022, 16'h0080, 16'h0012, SAT ? 16'h0050 : 16'h0013, SAT));
    add(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0012, 16'h0013, 1'b0));
    add(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'h0032, 16'h0000, 16'h0022, 16'h0080, 1'b1));
    add(mk(1'b0, 1'b0, 1'b1, 1'b1, 16'h0005, 16'h1234, 16'h0022, 16'h0080, 1'b1));
    add(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0005, 16'h1234, 1'b1));
    add(mk(1'b0, 1'b1, 1'b1, 1'b1, 16'h0033, 16'h0100, 16'h0022, 16'h0080, 1'b1));
    add(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0022, 16'h0023, 1'b0));
    add(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0033, 16'h0034, 1'b0));
    add(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0005, 16'h0006, 1'b0));
    add(mk(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0777, 16'hFFFF, 16'h0000, 1'b0));
    add(mk(1'b1, 1'b0, 1'b1, 1'b1, 16'h0005, 16'h0AAA, 16'hFFFF, 16'h0777, 1'b1));
    add(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b0));
    add(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0005, 16'h0006, 1'b0));
    add(mk(1'b0, 1'b0, 1'b1, 1'b1, 16'h0005, 16'h0AAA, 16'h0005, 16'h0006, 1'b0));
    add(mk(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0005, 16'h0AAA, 1'b1));

    // Reset with a taken update and flush pending: both must be ignored.
    reset = 1'b1;
    btb_flush = 1'b0;
    update_en = 1'b1;
    update_taken = 1'b1;
    update_PC = 16'h0012;
    update_target = 16'h0040;
    PC_IF = 16'h0012;
    @(negedge clk);
    #1;
    check("reset_hold", 0, predPC, pred_taken, 16'h0013, 1'b0);
    btb_flush = 1'b1;
    @(negedge clk);
    #1;
    check("reset_hold", 1, predPC, pred_taken, 16'h0013, 1'b0);

    for (int i = 0; i < nv; i++) begin
      @(negedge clk);
      reset         = vecs[i].rst;
      btb_flush     = vecs[i].flush;
      update_en     = vecs[i].ue;
      update_taken  = vecs[i].ut;
      update_PC     = vecs[i].upc;
      update_target = vecs[i].utgt;
      PC_IF         = vecs[i].pc;
      #1;
      check("vec", i, predPC, pred_taken, vecs[i].exp_pc, vecs[i].exp_tk);
    end

    @(negedge clk);
    reset = 1'b0;
    btb_flush = 1'b0;
    update_en = 1'b0;
    update_taken = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter: BTB_IDX_BITS, default 4, log2 of BTB entry count (16 entries).
REQ-002 Parameter: WORD_SIZE, default `WORD_SIZE (16), PC and target width.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port PC_IF, input, WORD_SIZE, PC of the instruction being fetched.
REQ-006 The block SHALL have port predPC, output, WORD_SIZE, predicted next PC fed to fetch and to hazard/flush logic.
REQ-007 The block SHALL have port pred_taken, output, 1, prediction is taken-to-target.
REQ-008 The block SHALL have port update_en, input, 1, resolved-branch update strobe from the resolve stage.
REQ-009 The block SHALL have port update_PC, input, WORD_SIZE, PC of the resolved branch.
REQ-010 The block SHALL have port update_target, input, WORD_SIZE, resolved taken target.
REQ-011 The block SHALL have port update_taken, input, 1, resolved direction.
REQ-012 The block SHALL have port btb_flush, input, 1, invalidate all entries.

Function
REQ-013 Each entry SHALL hold a valid bit, tag = PC[WORD_SIZE-1:BTB_IDX_BITS], target[WORD_SIZE-1:0] and a 2-bit saturating counter.
REQ-014 Index SHALL be PC[BTB_IDX_BITS-1:0]; hit = valid && tag match.
REQ-015 Lookup SHALL be combinational, zero latency: pred_taken = hit && counter[1]; predPC = pred_taken ? target : PC_IF+1.
REQ-016 PC_IF+1 SHALL wrap modulo 2^WORD_SIZE (16'hFFFF -> 16'h0000).
REQ-017 On update_en with miss and update_taken=1, the entry SHALL be allocated: valid=1, tag, target written, counter=2'b10; any previous occupant is replaced.
REQ-018 On update_en with miss and update_taken=0, no state SHALL change.
REQ-019 On update_en with hit, counter SHALL increment (taken) or decrement (not taken), saturating at 2'b11 and 2'b00; target SHALL be overwritten only when taken.
REQ-020 Updates SHALL become visible to lookup on the cycle after the update edge; same-cycle lookup of the same index SHALL return pre-update contents.
REQ-021 btb_flush SHALL clear every valid bit at the edge; if asserted together with update_en, the flush SHALL win and the update SHALL be dropped.
REQ-022 update_en SHALL be honoured regardless of pipeline stall; gating is the caller's responsibility.

Reset
REQ-023 While reset=1 at an edge, all valid bits SHALL clear, counters SHALL become 2'b01, and update_en/btb_flush SHALL be ignored.
REQ-024 After reset, predPC SHALL equal PC_IF+1 and pred_taken SHALL be 0 for every PC until an allocation occurs.
REQ-025 Reset asserted mid-sequence SHALL discard all learned state; no partial update SHALL persist.

Configuration
REQ-026 Macro BP_SATCNT_EN: when defined, counters SHALL be implemented as in REQ-013/017/019.
REQ-027 When BP_SATCNT_EN is undefined, counters SHALL be absent; pred_taken = hit; a not-taken update on a hit SHALL clear valid; a taken update SHALL allocate or refresh the entry.

Verification
REQ-028 Reset, PC_IF=16'h0010 -> predPC=16'h0011, pred_taken=0.
REQ-029 Update PC=16'h0012, target=16'h0040, taken=1; next cycle PC_IF=16'h0012 -> predPC=16'h0040, pred_taken=1.
REQ-030 Two not-taken updates to 16'h0012 after REQ-029 -> counter 2'b00, predPC=16'h0013; three taken updates -> counter 2'b11, a fourth taken update stays at 2'b11.
REQ-031 Alias: entry at 16'h0012 then taken update PC=16'h0022, target=16'h0080 -> 16'h0012 misses (predPC=16'h0013), 16'h0022 predicts 16'h0080.
REQ-032 btb_flush and update_en in the same cycle -> every PC predicts PC+1 next cycle; PC_IF=16'hFFFF with miss -> predPC=16'h0000.
